// File: rtl/fp_accel_master.sv
// Avalon-MM master for an FP accelerator: writes four operand words, then polls
// the result register until read data returns or the poll budget is spent.
module fp_accel_master #(
    parameter int unsigned RESP_TIMEOUT = 4,
    parameter int unsigned MAX_POLLS    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_w0,
    input  logic [31:0] cmd_w1,
    input  logic [31:0] cmd_w2,
    input  logic [31:0] cmd_w3,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic        busy,
    output logic [2:0]  masteraddress,
    output logic        masterwrite,
    output logic [31:0] masterwritedata,
    output logic        masterread,
    input  logic        masterwaitrequest,
    input  logic        masterreaddatavalid,
    input  logic [31:0] masterreaddata
);
    localparam logic [3:0] TMO_LOAD    = 4'(RESP_TIMEOUT);
    localparam logic [7:0] POLL_LIMIT  = 8'(MAX_POLLS);
    localparam logic [2:0] RESULT_ADDR = 3'h4;

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [3:0][31:0] words;
    logic [1:0]       idx;
    logic [7:0]       poll_cnt;
    logic [3:0]       tmo_cnt;
    logic             wr_done;
    logic             rd_accept;
    logic             tmo_last;
    logic             polls_left;

    assign wr_done    = (state == WR) && !masterwaitrequest;
    assign rd_accept  = (state == RD_REQ) && !masterwaitrequest;
    // Last RD_WAIT cycle is the one whose decrement brings the counter to zero,
    // giving RESP_TIMEOUT wait cycles per poll.
    assign tmo_last   = (tmo_cnt <= 4'd1);
    assign polls_left = (poll_cnt < POLL_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = WR;
            WR:      if (wr_done && idx == 2'd3) state_nxt = RD_REQ;
            RD_REQ:  if (rd_accept) state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (masterreaddatavalid)      state_nxt = RESP;
                else if (tmo_last)            state_nxt = polls_left ? RD_REQ : RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = (state == IDLE);
        busy            = (state != IDLE);
        rsp_valid       = (state == RESP);
        masterwrite     = 1'b0;
        masterread      = 1'b0;
        masteraddress   = '0;
        masterwritedata = '0;
        case (state)
            WR: begin
                masterwrite     = 1'b1;
                masteraddress   = {1'b0, idx};
                masterwritedata = words[idx];
            end
            RD_REQ: begin
                masterread    = 1'b1;
                masteraddress = RESULT_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words      <= '0;
            idx        <= '0;
            poll_cnt   <= '0;
            tmo_cnt    <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        words    <= {cmd_w3, cmd_w2, cmd_w1, cmd_w0};
                        idx      <= '0;
                        poll_cnt <= '0;
                    end
                end
                WR: begin
                    if (wr_done) idx <= idx + 2'd1;
                end
                RD_REQ: begin
                    if (rd_accept) begin
                        poll_cnt <= poll_cnt + 8'd1;
                        tmo_cnt  <= TMO_LOAD;
                    end
                end
                RD_WAIT: begin
                    if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 4'd1;
                    if (masterreaddatavalid) begin
                        rsp_result <= masterreaddata;
                        rsp_error  <= 1'b0;
                    end else if (tmo_last && !polls_left) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accel_master.sv
// Randomized scoreboard bench for fp_accel_master with a behavioural Avalon slave
// and a transaction-level model of the expected response and latency.
`timescale 1ns/1ps
module tb_fp_accel_master;
    localparam int unsigned RT   = 4;
    localparam int unsigned MAXP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_w0 = '0, cmd_w1 = '0, cmd_w2 = '0, cmd_w3 = '0;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        busy;
    logic [2:0]  masteraddress;
    logic        masterwrite;
    logic [31:0] masterwritedata;
    logic        masterread;
    logic        masterwaitrequest = 1'b0;
    logic        masterreaddatavalid = 1'b0;
    logic [31:0] masterreaddata = '0;

    fp_accel_master #(.RESP_TIMEOUT(RT), .MAX_POLLS(MAXP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_w0(cmd_w0), .cmd_w1(cmd_w1), .cmd_w2(cmd_w2), .cmd_w3(cmd_w3),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy),
        .masteraddress(masteraddress), .masterwrite(masterwrite),
        .masterwritedata(masterwritedata), .masterread(masterread),
        .masterwaitrequest(masterwaitrequest), .masterreaddatavalid(masterreaddatavalid),
        .masterreaddata(masterreaddata)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    // Scenario of the command in flight: operands, slave stalls, and which poll gets answered.
    logic [31:0] words [4];
    int unsigned wr_stall [4];
    int unsigned rd_stall = 0, ans_poll = 0, ans_delay = 1;
    logic [31:0] ans_data = '0;
    bit          spur_req = 1'b0;

    typedef struct {
        logic [31:0] result;
        logic        error;
        int unsigned reads;
        int unsigned lat;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_wr = 0, n_rd = 0, last_rd_cyc = 0, acc_cyc = 0;
    logic [31:0] held_result = '0;
    logic        held_error = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Avalon slave model plus bus protocol checks, evaluated mid-cycle.
    initial begin : slave
        int unsigned stall_cnt = 0;
        int unsigned vcount = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                vcount = 0;
                masterwaitrequest = 1'b0;
                masterreaddatavalid = 1'b0;
            end else begin
                masterreaddatavalid = 1'b0;
                if (vcount > 0) begin
                    vcount--;
                    if (vcount == 0) begin
                        masterreaddatavalid = 1'b1;
                        masterreaddata = ans_data;
                    end
                end
                if (spur_req && cmd_ready) begin
                    masterreaddatavalid = 1'b1;
                    masterreaddata = $urandom;
                    spur_req = 1'b0;
                end
                check("rd_wr_exclusive", 32'(masterwrite & masterread), 32'd0);
                if (!busy || rsp_valid)
                    check("bus_quiet", 32'({masterwrite, masterread}), 32'd0);
                if (masterwrite) begin
                    if (n_wr >= 4) begin
                        check("wr_extra", n_wr, 32'd3);
                        masterwaitrequest = 1'b0;
                    end else begin
                        check("wr_addr", 32'(masteraddress), n_wr);
                        check("wr_data", masterwritedata, words[n_wr]);
                        if (stall_cnt < wr_stall[n_wr]) begin
                            masterwaitrequest = 1'b1;
                            stall_cnt++;
                        end else begin
                            masterwaitrequest = 1'b0;
                            stall_cnt = 0;
                            n_wr++;
                        end
                    end
                end else if (masterread) begin
                    check("rd_addr", 32'(masteraddress), 32'd4);
                    check("rd_after_writes", n_wr, 32'd4);
                    if (stall_cnt < rd_stall) begin
                        masterwaitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        masterwaitrequest = 1'b0;
                        stall_cnt = 0;
                        n_rd++;
                        if (n_rd > 1) check("poll_spacing", cyc - last_rd_cyc, RT + 1 + rd_stall);
                        last_rd_cyc = cyc;
                        if (n_rd == ans_poll) vcount = ans_delay;
                    end
                end else begin
                    masterwaitrequest = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each rsp_valid, otherwise checks the held result.
    initial begin : monitor
        bit prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid) begin
                    check("rsp_single_cycle", 32'(prev_valid), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_result", rsp_result, e.result);
                        check("rsp_error", 32'(rsp_error), 32'(e.error));
                        check("read_count", n_rd, e.reads);
                        check("write_count", n_wr, 32'd4);
                        check("latency", cyc - acc_cyc, e.lat);
                        held_result = e.result;
                        held_error  = e.error;
                    end
                end else begin
                    check("rsp_result_hold", rsp_result, held_result);
                    check("rsp_error_hold", 32'(rsp_error), 32'(held_error));
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic run_cmd(input bit expect_rsp, input bit release_reset);
        exp_t e;
        bit answered;
        int unsigned np, sum_ws;
        answered = (ans_poll >= 1) && (ans_poll <= MAXP) && (ans_delay <= RT);
        np = answered ? ans_poll : MAXP;
        sum_ws = wr_stall[0] + wr_stall[1] + wr_stall[2] + wr_stall[3];
        e.result = answered ? ans_data : 32'h0;
        e.error  = !answered;
        e.reads  = np;
        e.lat    = 4 + sum_ws + np * (1 + rd_stall) + (np - 1) * RT + (answered ? ans_delay : RT);
        if (!release_reset) @(negedge clk);
        else reset = 1'b0;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        n_wr = 0;
        n_rd = 0;
        cmd_w0 = words[0];
        cmd_w1 = words[1];
        cmd_w2 = words[2];
        cmd_w3 = words[3];
        cmd_valid = 1'b1;
        if (expect_rsp) exp_q.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'({busy, cmd_ready}), 32'd2);
    endtask

    task automatic wait_rsp();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: got no response in 400 cycles, expected %0d pending", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic set_scenario(input int unsigned s0, input int unsigned s1, input int unsigned s2,
                                input int unsigned s3, input int unsigned rs, input int unsigned ap,
                                input int unsigned ad, input logic [31:0] data);
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        wr_stall[0] = s0; wr_stall[1] = s1; wr_stall[2] = s2; wr_stall[3] = s3;
        rd_stall = rs; ans_poll = ap; ans_delay = ad; ans_data = data;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_ready_busy", 32'({cmd_ready, busy, rsp_valid, rsp_error}), 32'h8);
        check("reset_bus", 32'({masterwrite, masterread, masteraddress}), 32'h0);
        check("reset_result", rsp_result, 32'h0);
        check("reset_wdata", masterwritedata, 32'h0);
        repeat (2) @(negedge clk);

        // Basic add, accepted on the first edge after reset release.
        set_scenario(0, 0, 0, 0, 0, 1, 1, 32'h40400000);
        words[2] = 32'h3F800000;
        words[3] = 32'h40000000;
        run_cmd(1'b1, 1'b1);
        wait_rsp();

        // Write and read stalls.
        set_scenario(0, 3, 0, 0, 2, 1, 1, 32'h12345678);
        run_cmd(1'b1, 1'b0);
        wait_rsp();

        // Slow result answered on the third poll.
        set_scenario(0, 0, 0, 0, 0, 3, 1, 32'hC0A00000);
        run_cmd(1'b1, 1'b0);
        wait_rsp();

        // Poll exhaustion.
        set_scenario(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
        run_cmd(1'b1, 1'b0);
        wait_rsp();

        // Valid in the final RD_WAIT cycle, then a spurious valid while idle.
        set_scenario(0, 0, 0, 0, 0, 1, RT, 32'h3E800000);
        run_cmd(1'b1, 1'b0);
        wait_rsp();
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_idle", 32'({cmd_ready, busy, rsp_valid}), 32'h4);

        // Reset while write address 2 is stalled.
        begin
            int unsigned t = 0;
            set_scenario(0, 0, 3, 0, 0, 1, 1, 32'h0BADF00D);
            run_cmd(1'b0, 1'b0);
            while (!(masterwrite && masteraddress == 3'd2) && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("reached_wr2", 32'({masterwrite, masteraddress}), 32'hA);
            reset = 1'b1;
            #1;
            check("rst_mid_bus", 32'({masterwrite, masterread, masteraddress}), 32'h0);
            check("rst_mid_ctrl", 32'({cmd_ready, busy, rsp_valid, rsp_error}), 32'h8);
            check("rst_mid_wdata", masterwritedata, 32'h0);
            check("rst_mid_result", rsp_result, 32'h0);
            held_result = '0;
            held_error  = 1'b0;
            repeat (2) @(negedge clk);
            set_scenario(0, 0, 0, 0, 0, 1, 1, 32'h41200000);
            run_cmd(1'b1, 1'b1);
            wait_rsp();
        end

        // Randomized commands.
        for (int n = 0; n < 30; n++) begin
            set_scenario($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                         $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, MAXP),
                         $urandom_range(1, RT + 1), $urandom);
            run_cmd(1'b1, 1'b0);
            wait_rsp();
            if ($urandom_range(0, 3) == 0) begin
                spur_req = 1'b1;
                repeat (2) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
